// File: rtl/imgproc_msg_pkg.sv
// Shared constants and types for the image processor message reader.
// Register map, default IDs, sequencer states and message field layout.
package imgproc_msg_pkg;

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_MSG    = 3'd1;
  localparam logic [2:0] ADDR_ID     = 3'd2;

  localparam logic [31:0] MSG_ID_DEF   = 32'h00524242;
  localparam logic [31:0] BLOCK_ID_DEF = 32'h1234EEE2;
  localparam int          POLL_GAP_DEF = 64;

  localparam int FLD_W     = 11;
  localparam int X_LSB     = 16;
  localparam int Y_LSB     = 0;
  localparam int WORDS_LSB = 8;
  localparam int WORDS_W   = 8;

  typedef enum logic [3:0] {
    S_ID_RD,
    S_ID_CAP,
    S_HALT,
    S_POLL_RD,
    S_POLL_CAP,
    S_GAP,
    S_WAIT,
    S_MSG_RD,
    S_MSG_CAP,
    S_HOLD
  } rd_state_e;

  function automatic logic [FLD_W-1:0] fld(
    input logic [31:0] w,
    input int          lsb
  );
    return w[lsb +: FLD_W];
  endfunction

endpackage

// File: rtl/imgproc_box_parser.sv
// Re-frames the message word stream into bounding-box records.
// Frame index persists across polls so messages may straddle them.
module imgproc_box_parser
  import imgproc_msg_pkg::*;
#(
  parameter logic [31:0] MSG_ID = MSG_ID_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             word_valid,
  input  logic [31:0]      word,
  input  logic             box_ready,
  output logic             box_valid,
  output logic [FLD_W-1:0] box_x_min,
  output logic [FLD_W-1:0] box_y_min,
  output logic [FLD_W-1:0] box_x_max,
  output logic [FLD_W-1:0] box_y_max,
  output logic [7:0]       sync_err,
  output logic [15:0]      msg_count,
  output logic             busy
);

  logic [1:0]       idx_q;
  logic [FLD_W-1:0] xs_q;
  logic [FLD_W-1:0] ys_q;
  logic             take;

  assign take = box_valid & box_ready;
  // a record completing this cycle counts as pending already
  assign busy = box_valid | (word_valid & (idx_q == 2'd2));

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q     <= 2'd0;
      xs_q      <= '0;
      ys_q      <= '0;
      box_valid <= 1'b0;
      box_x_min <= '0;
      box_y_min <= '0;
      box_x_max <= '0;
      box_y_max <= '0;
      sync_err  <= '0;
      msg_count <= '0;
    end else begin
      if (take) begin
        box_valid <= 1'b0;
        msg_count <= msg_count + 16'd1;
      end
      if (word_valid) begin
        unique case (idx_q)
          2'd0: begin
            if (word == MSG_ID)
              idx_q <= 2'd1;
            else if (sync_err != 8'hFF)
              sync_err <= sync_err + 8'd1;
          end
          2'd1: begin
            xs_q  <= fld(word, X_LSB);
            ys_q  <= fld(word, Y_LSB);
            idx_q <= 2'd2;
          end
          2'd2: begin
            box_x_min <= xs_q;
            box_y_min <= ys_q;
            box_x_max <= fld(word, X_LSB);
            box_y_max <= fld(word, Y_LSB);
            box_valid <= 1'b1;
            idx_q     <= 2'd0;
          end
          default: idx_q <= 2'd0;
        endcase
      end
    end
  end

endmodule

// File: rtl/imgproc_msg_reader.sv
// Bus-master sequencer: checks block ID, polls status, drains messages.
// Every slave access is an ISSUE/CAPTURE pair so strobes never abut.
module imgproc_msg_reader
  import imgproc_msg_pkg::*;
#(
  parameter int          POLL_GAP = POLL_GAP_DEF,
  parameter logic [31:0] MSG_ID   = MSG_ID_DEF,
  parameter logic [31:0] BLOCK_ID = BLOCK_ID_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [2:0]  m_address,
  input  logic [31:0] m_readdata,
  output logic        box_valid,
  input  logic        box_ready,
  output logic [10:0] box_x_min,
  output logic [10:0] box_y_min,
  output logic [10:0] box_x_max,
  output logic [10:0] box_y_max,
  output logic        id_ok,
  output logic        id_err,
  output logic [7:0]  sync_err,
  output logic [15:0] msg_count
);

  localparam int GAP_W = $clog2(POLL_GAP + 1);

  rd_state_e          state_q;
  rd_state_e          state_d;
  rd_state_e          poll_go;
  logic [WORDS_W-1:0] remain_q;
  logic [WORDS_W-1:0] words;
  logic [GAP_W-1:0]   gap_q;
  logic               id_ok_q;
  logic               id_err_q;
  logic               issue;
  logic               word_valid;
  logic               rec_busy;

  assign words = m_readdata[WORDS_LSB +: WORDS_W];

  // strobe is gated by reset so it drops in the reset cycle itself
  assign issue = ~reset & ((state_q == S_ID_RD) |
                           (state_q == S_POLL_RD) |
                           (state_q == S_MSG_RD));

  assign m_chipselect = issue;
  assign m_read       = issue;
  assign m_write      = 1'b0;
  assign word_valid   = ~reset & (state_q == S_MSG_CAP);
  assign id_ok        = id_ok_q;
  assign id_err       = id_err_q;

  always_comb begin
    m_address = ADDR_ID;
    if (!reset) begin
      unique case (state_q)
        S_POLL_RD, S_POLL_CAP, S_GAP, S_WAIT:
          m_address = ADDR_STATUS;
        S_MSG_RD, S_MSG_CAP, S_HOLD:
          m_address = ADDR_MSG;
        default:
          m_address = ADDR_ID;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    poll_go = enable ? S_POLL_RD : S_WAIT;
    unique case (state_q)
      S_ID_RD:
        state_d = S_ID_CAP;
      S_ID_CAP:
        state_d = (m_readdata == BLOCK_ID) ? poll_go : S_HALT;
      S_HALT:
        state_d = S_HALT;
      S_POLL_RD:
        state_d = S_POLL_CAP;
      S_POLL_CAP: begin
        if (words == '0)
          state_d = S_GAP;
        else if (rec_busy)
          state_d = S_HOLD;
        else
          state_d = S_MSG_RD;
      end
      S_GAP:
        if (gap_q == '0) state_d = poll_go;
      S_WAIT:
        if (enable) state_d = S_POLL_RD;
      S_MSG_RD:
        state_d = S_MSG_CAP;
      S_MSG_CAP: begin
        if (remain_q == '0)
          state_d = poll_go;
        else if (rec_busy)
          state_d = S_HOLD;
        else
          state_d = S_MSG_RD;
      end
      S_HOLD:
        if (box_valid & box_ready) state_d = S_MSG_RD;
      default:
        state_d = S_ID_RD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_ID_RD;
      remain_q <= '0;
      gap_q    <= '0;
      id_ok_q  <= 1'b0;
      id_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID_CAP) begin
        id_ok_q  <= (m_readdata == BLOCK_ID);
        id_err_q <= (m_readdata != BLOCK_ID);
      end
      if (state_q == S_POLL_CAP) begin
        remain_q <= words;
        gap_q    <= GAP_W'(POLL_GAP - 1);
      end
      if (state_q == S_MSG_RD)
        remain_q <= remain_q - 1'b1;
      if (state_q == S_GAP)
        gap_q <= gap_q - 1'b1;
    end
  end

  imgproc_box_parser #(
    .MSG_ID (MSG_ID)
  ) u_parser (
    .clk        (clk),
    .reset      (reset),
    .word_valid (word_valid),
    .word       (m_readdata),
    .box_ready  (box_ready),
    .box_valid  (box_valid),
    .box_x_min  (box_x_min),
    .box_y_min  (box_y_min),
    .box_x_max  (box_x_max),
    .box_y_max  (box_y_max),
    .sync_err   (sync_err),
    .msg_count  (msg_count),
    .busy       (rec_busy)
  );

endmodule

// File: tb/tb_imgproc_msg_reader.sv
// Bench for imgproc_msg_reader: slave model, stream-level reference,
// directed scenarios plus randomized message traffic.
module tb_imgproc_msg_reader;
  import imgproc_msg_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        m_chipselect, m_read, m_write;
  logic [2:0]  m_address;
  logic [31:0] m_readdata = '0;
  logic        box_valid;
  logic        box_ready = 1'b0;
  logic [10:0] box_x_min, box_y_min, box_x_max, box_y_max;
  logic        id_ok, id_err;
  logic [7:0]  sync_err;
  logic [15:0] msg_count;

  always #5 clk = ~clk;

  imgproc_msg_reader dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .m_chipselect (m_chipselect),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_address    (m_address),
    .m_readdata   (m_readdata),
    .box_valid    (box_valid),
    .box_ready    (box_ready),
    .box_x_min    (box_x_min),
    .box_y_min    (box_y_min),
    .box_x_max    (box_x_max),
    .box_y_max    (box_y_max),
    .id_ok        (id_ok),
    .id_err       (id_err),
    .sync_err     (sync_err),
    .msg_count    (msg_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [31:0] id_reg = BLOCK_ID_DEF;
  int          sq[$];
  logic [31:0] mq[$];
  logic [31:0] wl[$];
  logic [43:0] got_q[$];
  logic [43:0] exp_q[$];
  int          exp_sync;
  int cyc = 0;
  int n_id, n_status, n_msg, adj_cnt, held_rd, unstable, wr_cnt, underflow;
  int id_cyc, first_poll, first_msg, rise_cyc, last_poll, pmin, pmax;
  bit prev_strobe, prev_valid, prev_take;
  logic [43:0] prev_box;
  int ready_mode = 0;
  int en_mode = 0;

  function automatic logic [43:0] cur_box();
    return {box_x_min, box_y_min, box_x_max, box_y_max};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    box_ready = (ready_mode == 1) ||
                (ready_mode == 2 && $urandom_range(0, 2) != 0);
    enable = (en_mode == 1) ||
             (en_mode == 2 && $urandom_range(0, 9) != 0);
  end

  // slave register model and protocol monitor
  initial forever begin
    bit strobe;
    int b;
    @(negedge clk);
    strobe = m_chipselect && m_read;
    if (strobe) begin
      if (prev_strobe) adj_cnt++;
      case (m_address)
        ADDR_ID: begin
          n_id++;
          id_cyc = cyc;
          m_readdata = id_reg;
        end
        ADDR_STATUS: begin
          n_status++;
          if (first_poll < 0) first_poll = cyc;
          if (last_poll >= 0) begin
            if (cyc - last_poll < pmin) pmin = cyc - last_poll;
            if (cyc - last_poll > pmax) pmax = cyc - last_poll;
          end
          last_poll = cyc;
          b = 0;
          if (sq.size() > 0) b = sq.pop_front();
          m_readdata = {16'h0, 8'(b), 8'h0};
        end
        ADDR_MSG: begin
          n_msg++;
          if (first_msg < 0) first_msg = cyc;
          if (box_valid) held_rd++;
          if (mq.size() > 0) m_readdata = mq.pop_front();
          else begin
            underflow++;
            m_readdata = '0;
          end
        end
        default: m_readdata = '0;
      endcase
    end
    if (m_write) wr_cnt++;
    if (box_valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
    if (prev_valid && box_valid && !prev_take && cur_box() != prev_box)
      unstable++;
    if (box_valid && box_ready) got_q.push_back(cur_box());
    prev_take   = box_valid && box_ready;
    prev_valid  = box_valid;
    prev_box    = cur_box();
    prev_strobe = strobe;
  end

  task automatic rst_on();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sq.delete(); mq.delete(); wl.delete();
    got_q.delete(); exp_q.delete();
    exp_sync = 0;
    n_id = 0; n_status = 0; n_msg = 0; adj_cnt = 0; held_rd = 0;
    unstable = 0; wr_cnt = 0; underflow = 0;
    id_cyc = -1; first_poll = -1; first_msg = -1; rise_cyc = -1;
    last_poll = -1; pmin = 1000000; pmax = 0;
  endtask

  task automatic add_msg(input logic [10:0] a, input logic [10:0] b,
                         input logic [10:0] c, input logic [10:0] d,
                         input bit noisy);
    logic [4:0] h[4];
    for (int i = 0; i < 4; i++) h[i] = noisy ? 5'($urandom) : 5'd0;
    wl.push_back(MSG_ID_DEF);
    wl.push_back({h[0], a, h[1], b});
    wl.push_back({h[2], c, h[3], d});
  endtask

  // stream-level reference: scan for complete frames, count the rest
  task automatic model_load();
    int i = 0;
    exp_sync = 0;
    while (i < wl.size()) begin
      if (wl[i] == MSG_ID_DEF && i + 2 < wl.size()) begin
        exp_q.push_back({wl[i+1][26:16], wl[i+1][10:0],
                         wl[i+2][26:16], wl[i+2][10:0]});
        i += 3;
      end else begin
        exp_sync++;
        i++;
      end
    end
    if (exp_sync > 255) exp_sync = 255;
    foreach (wl[k]) mq.push_back(wl[k]);
  endtask

  task automatic wait_recs(input int n, input int budget);
    for (int c = 0; c < budget && got_q.size() < n; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_run();
    chk("rec_cnt", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("rec", got_q[i], exp_q[i]);
    chk("sync_err", sync_err, exp_sync);
    chk("msg_count", msg_count, exp_q.size());
    chk("adjacent", adj_cnt, 0);
    chk("held_rd", held_rd, 0);
    chk("unstable", unstable, 0);
    chk("underflow", underflow, 0);
    chk("drained", mq.size(), 0);
    chk("m_write", wr_cnt, 0);
  endtask

  initial begin
    // reset values, then ID mismatch halts the reader
    id_reg = 32'hDEADBEEF;
    en_mode = 1;
    ready_mode = 1;
    rst_on();
    chk("rst_cs", m_chipselect, 0);
    chk("rst_rd", m_read, 0);
    chk("rst_wr", m_write, 0);
    chk("rst_addr", m_address, 2);
    chk("rst_valid", box_valid, 0);
    chk("rst_box", cur_box(), 0);
    chk("rst_idok", id_ok, 0);
    chk("rst_iderr", id_err, 0);
    chk("rst_sync", sync_err, 0);
    chk("rst_cnt", msg_count, 0);
    reset = 1'b0;
    #1;
    chk("first_rd", m_read, 1);
    chk("first_addr", m_address, 2);
    repeat (300) @(posedge clk);
    #1;
    chk("iderr", id_err, 1);
    chk("idok_lo", id_ok, 0);
    chk("halt_ids", n_id, 1);
    chk("halt_reads", n_status + n_msg, 0);

    // enable held low, then empty buffer polling period
    id_reg = BLOCK_ID_DEF;
    en_mode = 0;
    rst_on();
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("dis_polls", n_status, 0);
    chk("idok", id_ok, 1);
    en_mode = 1;
    repeat (400) @(posedge clk);
    #1;
    chk("poll_min", pmin, POLL_GAP_DEF + 2);
    chk("poll_max", pmax, POLL_GAP_DEF + 2);
    chk("poll_cnt_ge5", n_status >= 5, 1);
    chk("empty_msg", n_msg, 0);

    // single message, latency and first-poll placement
    rst_on();
    add_msg(11'd10, 11'd20, 11'd100, 11'd200, 1'b0);
    model_load();
    sq.push_back(3);
    reset = 1'b0;
    wait_recs(1, 500);
    check_run();
    chk("one_box", exp_q[0], {11'd10, 11'd20, 11'd100, 11'd200});
    chk("latency", rise_cyc - first_msg, 6);
    chk("poll_after_id", first_poll - id_cyc, 2);

    // straddled messages under backpressure
    rst_on();
    ready_mode = 0;
    add_msg(11'd1, 11'd2, 11'd3, 11'd4, 1'b1);
    add_msg(11'd2047, 11'd0, 11'd1024, 11'd777, 1'b1);
    model_load();
    sq.push_back(2);
    sq.push_back(4);
    reset = 1'b0;
    for (int c = 0; c < 500 && !box_valid; c++) @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    chk("bp_valid", box_valid, 1);
    chk("bp_hold", cur_box(), exp_q[0]);
    chk("bp_reads", n_msg, 3);
    ready_mode = 1;
    wait_recs(2, 500);
    check_run();

    // desync words ahead of a valid message
    rst_on();
    wl.push_back(32'h1);
    wl.push_back(32'h2);
    add_msg(11'd5, 11'd6, 11'd7, 11'd8, 1'b0);
    model_load();
    sq.push_back(5);
    reset = 1'b0;
    wait_recs(1, 500);
    check_run();
    chk("desync", sync_err, 2);

    // randomized traffic, random backpressure and enable
    for (int r = 0; r < 8; r++) begin
      int nm, rem, b;
      logic [31:0] w;
      rst_on();
      nm = $urandom_range(1, 4);
      for (int m = 0; m < nm; m++) begin
        for (int j = $urandom_range(0, 2); j > 0; j--) begin
          w = $urandom;
          if (w == MSG_ID_DEF) w = 32'h0;
          wl.push_back(w);
        end
        add_msg(11'($urandom), 11'($urandom), 11'($urandom),
                11'($urandom), 1'b1);
      end
      model_load();
      rem = wl.size();
      while (rem > 0) begin
        if ($urandom_range(0, 4) == 0) sq.push_back(0);
        b = $urandom_range(1, rem < 7 ? rem : 7);
        sq.push_back(b);
        rem -= b;
      end
      ready_mode = 2;
      en_mode = 2;
      reset = 1'b0;
      wait_recs(exp_q.size(), 6000);
      check_run();
    end

    // reset during capture of the second message word
    ready_mode = 1;
    en_mode = 1;
    rst_on();
    add_msg(11'd9, 11'd9, 11'd9, 11'd9, 1'b0);
    model_load();
    sq.push_back(3);
    reset = 1'b0;
    for (int c = 0; c < 500 && n_msg < 2; c++) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rd", m_read, 0);
    chk("mid_cs", m_chipselect, 0);
    chk("mid_addr", m_address, 2);
    chk("mid_valid", box_valid, 0);
    chk("mid_box", cur_box(), 0);
    chk("mid_cnt", msg_count, 0);
    chk("mid_sync", sync_err, 0);
    chk("mid_id", {id_ok, id_err}, 0);
    reset = 1'b0;
    #1;
    chk("restart_rd", m_read, 1);
    chk("restart_addr", m_address, 2);
    repeat (100) @(posedge clk);
    #1;
    chk("no_partial", got_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
